// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: fixed-priority stall/flush arbitration for the 5-stage pipeline; STALL_PERF_CNT_EN enables stall counters
module pipeline_stall_controller #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 hazard_detect_signal,
    input  logic                 branch_taken_EX,
    input  logic                 dcache_busy,
    input  logic                 icache_busy,
    input  logic                 perf_clear,
    output logic                 pc_write_en,
    output logic                 if_id_write_en,
    output logic                 if_id_flush,
    output logic                 id_ex_write_en,
    output logic                 id_ex_bubble,
    output logic                 ex_mem_write_en,
    output logic                 mem_wb_write_en,
    output logic [2:0]           stall_state,
    output logic [CNT_WIDTH-1:0] load_stall_count,
    output logic [CNT_WIDTH-1:0] flush_count,
    output logic [CNT_WIDTH-1:0] mem_stall_count
);
    typedef enum logic [2:0] {
        RUN        = 3'd0,
        LOAD_STALL = 3'd1,
        FLUSH      = 3'd2,
        DMEM_WAIT  = 3'd3,
        IMEM_WAIT  = 3'd4
    } action_t;

    action_t action;
    logic    flush_pending;
    logic    load_stall_done;

    // Choose this cycle's action; a data-memory freeze outranks everything
    always_comb begin
        action = dcache_busy ? DMEM_WAIT :
                 (branch_taken_EX || flush_pending) ? FLUSH :
                 (hazard_detect_signal && !load_stall_done) ? LOAD_STALL :
                 icache_busy ? IMEM_WAIT : RUN;
    end

    // Decode the action into stage controls; reset holds every stage as a bubble
    always_comb begin
        pc_write_en     = RESET && (action == RUN || action == FLUSH);
        if_id_write_en  = RESET && !(action == LOAD_STALL || action == DMEM_WAIT);
        if_id_flush     = !RESET || action == FLUSH || action == IMEM_WAIT;
        id_ex_write_en  = RESET && action != DMEM_WAIT;
        id_ex_bubble    = !RESET || action == FLUSH || action == LOAD_STALL;
        ex_mem_write_en = RESET && action != DMEM_WAIT;
        mem_wb_write_en = RESET && action != DMEM_WAIT;
    end

    // Defer branches seen during a freeze; allow one bubble per held hazard
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            flush_pending   <= 1'b0;
            load_stall_done <= 1'b0;
            stall_state     <= RUN;
        end else begin
            flush_pending <= dcache_busy && (flush_pending || branch_taken_EX);
            if (action != DMEM_WAIT)
                load_stall_done <= action == LOAD_STALL || (hazard_detect_signal && load_stall_done);
            stall_state <= action;
        end
    end

`ifdef STALL_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] MAX = '1;
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    // Saturating stall counters; a clear wins over a same-cycle increment
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET || perf_clear) begin
            load_stall_count <= '0;
            flush_count      <= '0;
            mem_stall_count  <= '0;
        end else begin
            if (action == LOAD_STALL && load_stall_count != MAX)
                load_stall_count <= load_stall_count + ONE;
            if (action == FLUSH && flush_count != MAX)
                flush_count <= flush_count + ONE;
            if ((action == DMEM_WAIT || action == IMEM_WAIT) && mem_stall_count != MAX)
                mem_stall_count <= mem_stall_count + ONE;
        end
    end
`else
    logic unused_perf_clear;
    assign unused_perf_clear = perf_clear;
    assign load_stall_count  = '0;
    assign flush_count       = '0;
    assign mem_stall_count   = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: table vectors, corner sequences and random stimulus against a behavioural model
module tb_pipeline_stall_controller;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic CLK = 0, RESET = 0;
    logic hz = 0, br = 0, dc = 0, ic = 0, pclr = 0;
    logic pc_we, ifid_we, ifid_fl, idex_we, idex_bub, exmem_we, memwb_we;
    logic [2:0] st;
    logic [CW-1:0] c_ls, c_fl, c_ms;

    pipeline_stall_controller #(.CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RESET(RESET),
        .hazard_detect_signal(hz), .branch_taken_EX(br),
        .dcache_busy(dc), .icache_busy(ic), .perf_clear(pclr),
        .pc_write_en(pc_we), .if_id_write_en(ifid_we), .if_id_flush(ifid_fl),
        .id_ex_write_en(idex_we), .id_ex_bubble(idex_bub),
        .ex_mem_write_en(exmem_we), .mem_wb_write_en(memwb_we),
        .stall_state(st), .load_stall_count(c_ls), .flush_count(c_fl), .mem_stall_count(c_ms)
    );

    always #5 CLK = ~CLK;

    wire [6:0] ctl = {pc_we, ifid_we, ifid_fl, idex_we, idex_bub, exmem_we, memwb_we};

    // control word per action: {pc, ifid_we, ifid_flush, idex_we, idex_bubble, exmem, memwb}
    logic [6:0] ctl_of [5];
    localparam logic [6:0] CTL_RESET = 7'b0010100;

    int n_vec = 0, n_bad = 0;

    // behavioural reference state
    bit deferred_branch, bubble_given;
    int cnt_ls, cnt_fl, cnt_ms, last_action;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decide(bit h, bit b, bit d, bit i);
        if (d) return 3;
        if (b || deferred_branch) return 2;
        if (h && !bubble_given) return 1;
        if (i) return 4;
        return 0;
    endfunction

    function automatic int bump(int v, bit hit);
        return (hit && v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_edge(input bit h, input bit b, input bit d, input bit i, input bit clr);
        int a;
        a = decide(h, b, d, i);
        if (d) deferred_branch = deferred_branch | b;
        else begin
            deferred_branch = 0;
            if (a == 1) bubble_given = 1;
            else if (!h) bubble_given = 0;
        end
        last_action = a;
`ifdef STALL_PERF_CNT_EN
        if (clr) begin cnt_ls = 0; cnt_fl = 0; cnt_ms = 0; end
        else begin
            cnt_ls = bump(cnt_ls, a == 1);
            cnt_fl = bump(cnt_fl, a == 2);
            cnt_ms = bump(cnt_ms, a == 3 || a == 4);
        end
`else
        if (clr) cnt_ls = 0;
`endif
    endtask

    task automatic model_reset();
        deferred_branch = 0; bubble_given = 0; last_action = 0;
        cnt_ls = 0; cnt_fl = 0; cnt_ms = 0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".state"}, 32'(st), 32'(last_action));
        check({tag, ".ls_cnt"}, 32'(c_ls), 32'(cnt_ls));
        check({tag, ".fl_cnt"}, 32'(c_fl), 32'(cnt_fl));
        check({tag, ".ms_cnt"}, 32'(c_ms), 32'(cnt_ms));
    endtask

    // one cycle: drive just after an edge, sample mid-cycle, clock, sample after the edge
    task automatic step(input bit h, input bit b, input bit d, input bit i, input bit clr,
                        input string tag, output logic [6:0] got_ctl);
        hz = h; br = b; dc = d; ic = i; pclr = clr;
        #4;
        got_ctl = ctl;
        check({tag, ".ctl"}, 32'(ctl), 32'(ctl_of[decide(h, b, d, i)]));
        @(posedge CLK);
        model_edge(h, b, d, i, clr);
        #1;
        check_regs(tag);
    endtask

    typedef struct {
        bit h, b, d, i;
        logic [6:0] ctl;
        logic [2:0] st;
    } vec_t;

    vec_t tbl [25];
    logic [6:0] g;

    initial begin
        ctl_of[0] = 7'b1101011;
        ctl_of[1] = 7'b0001111;
        ctl_of[2] = 7'b1111111;
        ctl_of[3] = 7'b0000000;
        ctl_of[4] = 7'b0111011;

        tbl[0]  = '{0,0,0,0, 7'b1101011, 3'd0};
        tbl[1]  = '{1,0,0,0, 7'b0001111, 3'd1};
        tbl[2]  = '{1,0,0,0, 7'b1101011, 3'd0};
        tbl[3]  = '{0,0,0,0, 7'b1101011, 3'd0};
        tbl[4]  = '{0,1,1,0, 7'b0000000, 3'd3};
        tbl[5]  = '{0,0,1,0, 7'b0000000, 3'd3};
        tbl[6]  = '{0,0,1,0, 7'b0000000, 3'd3};
        tbl[7]  = '{0,0,0,0, 7'b1111111, 3'd2};
        tbl[8]  = '{0,0,0,0, 7'b1101011, 3'd0};
        tbl[9]  = '{1,1,0,1, 7'b1111111, 3'd2};
        tbl[10] = '{0,0,0,1, 7'b0111011, 3'd4};
        tbl[11] = '{0,0,0,1, 7'b0111011, 3'd4};
        tbl[12] = '{0,0,0,1, 7'b0111011, 3'd4};
        tbl[13] = '{0,0,0,1, 7'b0111011, 3'd4};
        tbl[14] = '{1,0,0,1, 7'b0001111, 3'd1};
        tbl[15] = '{1,0,0,1, 7'b0111011, 3'd4};
        tbl[16] = '{1,0,1,0, 7'b0000000, 3'd3};
        tbl[17] = '{1,0,0,0, 7'b1101011, 3'd0};
        tbl[18] = '{0,0,0,0, 7'b1101011, 3'd0};
        tbl[19] = '{1,0,1,0, 7'b0000000, 3'd3};
        tbl[20] = '{1,0,0,0, 7'b0001111, 3'd1};
        tbl[21] = '{0,1,1,0, 7'b0000000, 3'd3};
        tbl[22] = '{0,1,1,0, 7'b0000000, 3'd3};
        tbl[23] = '{0,0,0,0, 7'b1111111, 3'd2};
        tbl[24] = '{0,0,0,0, 7'b1101011, 3'd0};

        model_reset();
        #2;
        check("reset.ctl", 32'(ctl), 32'(CTL_RESET));
        check_regs("reset");
        @(posedge CLK); #1;
        RESET = 1;

        for (int k = 0; k < 25; k++) begin
            step(tbl[k].h, tbl[k].b, tbl[k].d, tbl[k].i, 0, $sformatf("tbl%0d", k), g);
            check($sformatf("tbl%0d.ctl_tab", k), 32'(g), 32'(tbl[k].ctl));
            check($sformatf("tbl%0d.st_tab", k), 32'(st), 32'(tbl[k].st));
        end

        // reset pulse in the middle of a freeze with a branch deferred
        step(0, 1, 1, 0, 0, "frz", g);
        dc = 1; br = 0; #2;
        RESET = 0; #1;
        check("rstfrz.ctl", 32'(ctl), 32'(CTL_RESET));
        model_reset();
        check_regs("rstfrz");
        @(posedge CLK); #1;
        check_regs("rstfrz_edge");
        #1 RESET = 1;
        step(0, 0, 0, 0, 0, "after_rst", g);
        check("after_rst.run", 32'(st), 32'd0);

        // 20 separate load stalls saturate the counter, then clear
        for (int k = 0; k < 20; k++) begin
            step(1, 0, 0, 0, 0, "sat_h", g);
            step(0, 0, 0, 0, 0, "sat_l", g);
        end
`ifdef STALL_PERF_CNT_EN
        check("sat.ls15", 32'(c_ls), 32'd15);
`endif
        step(1, 0, 0, 0, 1, "clr_inc", g);
        check("clr.ls0", 32'(c_ls), 32'd0);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++)
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0), "rnd", g);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
